// File: rtl/alien_formation.sv
// alien_formation: alien grid state, sweep motion, laser hits and end-of-game flags.
// Also produces the registered per-pixel "alien here" flag for the colour stage.
module alien_formation #(
    parameter int ROWS     = 3,
    parameter int COLS     = 12,
    parameter int ALIEN_W  = 16,
    parameter int ALIEN_H  = 16,
    parameter int GAP_X    = 8,
    parameter int GAP_Y    = 8,
    parameter int STEP_X   = 2,
    parameter int STEP_Y   = 16,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int X_START  = 32,
    parameter int Y_START  = 32,
    parameter int Y_DEFEAT = 400
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                step,
    input  logic [9:0]                          hPos,
    input  logic [9:0]                          vPos,
    input  logic [9:0]                          xLaser,
    input  logic [9:0]                          yLaser,
    input  logic                                laserActive,
    output logic                                killingAlien,
    output logic [ROWS*COLS-1:0]                alive,
    output logic [$clog2(ROWS*COLS+1)-1:0]      aliveCount,
    output logic [9:0]                          xAlien,
    output logic [9:0]                          yAlien,
    output logic                                pixelOn,
    output logic                                victory,
    output logic                                defeat
);

    localparam int N  = ROWS * COLS;
    localparam int CW = $clog2(N + 1);
    localparam int PX = ALIEN_W + GAP_X;
    localparam int PY = ALIEN_H + GAP_Y;

    typedef enum logic [1:0] {RIGHT, LEFT, FROZEN} state_t;

    state_t         state;
    logic           armed;
    logic           descended;

    logic [COLS-1:0] colAlive;
    logic [ROWS-1:0] rowAlive;
    int              cMin, cMax, rMax;
    int              edgeL, edgeR, edgeB;
    logic [N-1:0]    hitMask;
    logic [N-1:0]    pixMask;
    logic            hit;
    logic            atRight, atLeft;
    logic            winNow, loseNow;

    // Mask of live cells containing point (px,py); gaps hit nothing.
    function automatic logic [N-1:0] cellMask(
        input logic [9:0] px,
        input logic [9:0] py,
        input logic [9:0] xa,
        input logic [9:0] ya,
        input logic [N-1:0] am
    );
        logic [N-1:0] m;
        int x0, y0;
        m = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                x0 = int'(xa) + c * PX;
                y0 = int'(ya) + r * PY;
                if (int'(px) >= x0 && int'(px) <= x0 + ALIEN_W - 1 &&
                    int'(py) >= y0 && int'(py) <= y0 + ALIEN_H - 1)
                    m[r*COLS+c] = am[r*COLS+c];
            end
        end
        return m;
    endfunction

    // Formation edges derived from surviving columns and rows only.
    always_comb begin
        colAlive = '0;
        rowAlive = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                colAlive[c] = colAlive[c] | alive[r*COLS+c];
                rowAlive[r] = rowAlive[r] | alive[r*COLS+c];
            end
        end
        cMin = 0;
        cMax = 0;
        rMax = 0;
        for (int c = COLS - 1; c >= 0; c--)
            if (colAlive[c]) cMin = c;
        for (int c = 0; c < COLS; c++)
            if (colAlive[c]) cMax = c;
        for (int r = 0; r < ROWS; r++)
            if (rowAlive[r]) rMax = r;
        edgeL = cMin * PX;
        edgeR = cMax * PX + ALIEN_W - 1;
        edgeB = rMax * PY + ALIEN_H - 1;
    end

    // Hit, pixel and boundary decisions for this cycle.
    always_comb begin
        hitMask = cellMask(xLaser, yLaser, xAlien, yAlien, alive);
        pixMask = cellMask(hPos, vPos, xAlien, yAlien, alive);
        hit     = laserActive && armed && (state != FROZEN) && (|hitMask);
        atRight = (int'(xAlien) + edgeR + STEP_X) > X_MAX;
        atLeft  = (int'(xAlien) + edgeL - STEP_X) < X_MIN;
        winNow  = (aliveCount == '0);
        loseNow = descended && ((int'(yAlien) + edgeB) >= Y_DEFEAT);
    end

    // Motion FSM, kill handling, end-of-game flags and pixel flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            alive        <= '1;
            aliveCount   <= CW'(N);
            xAlien       <= 10'(X_START);
            yAlien       <= 10'(Y_START);
            state        <= RIGHT;
            armed        <= 1'b1;
            descended    <= 1'b0;
            killingAlien <= 1'b0;
            pixelOn      <= 1'b0;
            victory      <= 1'b0;
            defeat       <= 1'b0;
        end else begin
            killingAlien <= hit;
            pixelOn      <= |pixMask;
            descended    <= 1'b0;
            if (!laserActive)
                armed <= 1'b1;
            else if (hit)
                armed <= 1'b0;
            if (hit) begin
                alive      <= alive & ~hitMask;
                aliveCount <= aliveCount - CW'(1);
            end
            if (state != FROZEN && winNow) begin
                victory <= 1'b1;
                state   <= FROZEN;
            end else if (state != FROZEN && loseNow) begin
                defeat <= 1'b1;
                state  <= FROZEN;
            end else if (step && !winNow) begin
                unique case (state)
                    RIGHT: begin
                        if (atRight) begin
                            yAlien    <= yAlien + 10'(STEP_Y);
                            state     <= LEFT;
                            descended <= 1'b1;
                        end else begin
                            xAlien <= xAlien + 10'(STEP_X);
                        end
                    end
                    LEFT: begin
                        if (atLeft) begin
                            yAlien    <= yAlien + 10'(STEP_Y);
                            state     <= RIGHT;
                            descended <= 1'b1;
                        end else begin
                            xAlien <= xAlien - 10'(STEP_X);
                        end
                    end
                    FROZEN: ;
                    default: state <= FROZEN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alien_formation.sv
// tb_alien_formation: vector tables plus a kill/pixel scoreboard for alien_formation.
// Covers reset, sweep timing, laser arming, gaps, victory, defeat and mid-game reset.
module tb_alien_formation;

    logic        clk = 1'b0;
    logic        reset, step, laserActive;
    logic [9:0]  hPos, vPos, xLaser, yLaser;
    logic        killingAlien, pixelOn, victory, defeat;
    logic [35:0] alive;
    logic [5:0]  aliveCount;
    logic [9:0]  xAlien, yAlien;

    int nTests = 0;
    int nFail  = 0;

    typedef struct {
        string name;
        int    sel;
        int    exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        int         exp;
    } pvec_t;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        int         expKill;
        int         bitIdx;
    } lvec_t;

    pvec_t pv[10];
    lvec_t lv[8];

    alien_formation dut (
        .clk(clk), .reset(reset), .step(step),
        .hPos(hPos), .vPos(vPos),
        .xLaser(xLaser), .yLaser(yLaser),
        .laserActive(laserActive),
        .killingAlien(killingAlien), .alive(alive),
        .aliveCount(aliveCount),
        .xAlien(xAlien), .yAlien(yAlien),
        .pixelOn(pixelOn),
        .victory(victory), .defeat(defeat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        nTests++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input string name, input int sel, input int exp);
        sb_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    task automatic pop();
        sb_t e;
        if (sbq.size() == 0) begin
            check("sbEmpty", 1, 0);
        end else begin
            e = sbq.pop_front();
            check(e.name, (e.sel == 0) ? int'(pixelOn) : int'(killingAlien), e.exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_alive"}, int'(alive == '1), 1);
        check({tag, "_count"}, int'(aliveCount), 36);
        check({tag, "_x"}, int'(xAlien), 32);
        check({tag, "_y"}, int'(yAlien), 32);
        check({tag, "_kill"}, int'(killingAlien), 0);
        check({tag, "_pix"}, int'(pixelOn), 0);
        check({tag, "_vic"}, int'(victory), 0);
        check({tag, "_def"}, int'(defeat), 0);
    endtask

    task automatic doSteps(input int n);
        step = 1'b1;
        repeat (n) tick();
        step = 1'b0;
    endtask

    task automatic fire(input int x, input int y);
        laserActive = 1'b0;
        tick();
        laserActive = 1'b1;
        xLaser = 10'(x);
        yLaser = 10'(y);
        tick();
    endtask

    initial begin
        int pulses;
        int expCount;
        int n;
        logic [9:0] xHold;

        pv[0] = '{10'd32,  10'd32, 1};
        pv[1] = '{10'd47,  10'd47, 1};
        pv[2] = '{10'd48,  10'd32, 0};
        pv[3] = '{10'd56,  10'd32, 1};
        pv[4] = '{10'd31,  10'd32, 0};
        pv[5] = '{10'd32,  10'd48, 0};
        pv[6] = '{10'd32,  10'd56, 1};
        pv[7] = '{10'd311, 10'd95, 1};
        pv[8] = '{10'd312, 10'd95, 0};
        pv[9] = '{10'd311, 10'd96, 0};

        lv[0] = '{10'd48,  10'd32,  0, -1};
        lv[1] = '{10'd32,  10'd32,  0, -1};
        lv[2] = '{10'd80,  10'd56,  1, 14};
        lv[3] = '{10'd311, 10'd95,  1, 35};
        lv[4] = '{10'd0,   10'd0,   0, -1};
        lv[5] = '{10'd312, 10'd95,  0, -1};
        lv[6] = '{10'd56,  10'd32,  0, -1};
        lv[7] = '{10'd104, 10'd104, 0, -1};

        step = 0;
        laserActive = 0;
        hPos = 0;
        vPos = 0;
        xLaser = 0;
        yLaser = 0;
        doReset();
        checkReset("rst");

        for (int i = 0; i < 10; i++) begin
            hPos = pv[i].h;
            vPos = pv[i].v;
            push($sformatf("pix%0d", i), 0, pv[i].exp);
            tick();
            pop();
        end

        doSteps(164);
        check("sweep_x164", int'(xAlien), 360);
        check("sweep_y164", int'(yAlien), 32);
        doSteps(1);
        check("sweep_x165", int'(xAlien), 360);
        check("sweep_y165", int'(yAlien), 48);
        doSteps(1);
        check("sweep_xLeft", int'(xAlien), 358);

        doReset();
        laserActive = 1'b1;
        xLaser = 10'd32;
        yLaser = 10'd32;
        tick();
        check("kill_latency", int'(killingAlien), 1);
        pulses = int'(killingAlien);
        repeat (9) begin
            tick();
            pulses += int'(killingAlien);
        end
        check("kill_pulses", pulses, 1);
        check("kill_alive0", int'(alive[0]), 0);
        check("kill_count", int'(aliveCount), 35);
        xLaser = 10'd56;
        pulses = 0;
        repeat (5) begin
            tick();
            pulses += int'(killingAlien);
        end
        check("disarmed_pulses", pulses, 0);
        check("disarmed_alive1", int'(alive[1]), 1);
        fire(56, 32);
        check("rearm_kill", int'(killingAlien), 1);
        check("rearm_alive1", int'(alive[1]), 0);
        check("rearm_count", int'(aliveCount), 34);

        fire(48, 32);
        pulses = int'(killingAlien);
        repeat (20) begin
            tick();
            pulses += int'(killingAlien);
        end
        check("gap_hold", pulses, 0);

        expCount = 34;
        for (int i = 0; i < 8; i++) begin
            laserActive = 1'b0;
            tick();
            laserActive = 1'b1;
            xLaser = lv[i].x;
            yLaser = lv[i].y;
            push($sformatf("laser%0d", i), 1, lv[i].expKill);
            tick();
            pop();
            if (lv[i].expKill != 0) expCount--;
            if (lv[i].bitIdx >= 0)
                check($sformatf("laser%0d_bit", i), int'(alive[lv[i].bitIdx]), 0);
            check($sformatf("laser%0d_count", i), int'(aliveCount), expCount);
        end
        laserActive = 1'b0;

        doReset();
        fire(296, 32);
        fire(296, 56);
        fire(296, 80);
        laserActive = 1'b0;
        tick();
        check("col11_count", int'(aliveCount), 33);
        doSteps(176);
        check("col11_x176", int'(xAlien), 384);
        check("col11_y176", int'(yAlien), 32);
        doSteps(1);
        check("col11_x177", int'(xAlien), 384);
        check("col11_y177", int'(yAlien), 48);

        doReset();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 12; c++) begin
                fire(32 + c * 24, 32 + r * 24);
            end
        end
        check("last_kill", int'(killingAlien), 1);
        check("last_count", int'(aliveCount), 0);
        check("vic_early", int'(victory), 0);
        laserActive = 1'b0;
        tick();
        check("vic_set", int'(victory), 1);
        check("vic_alive", int'(alive == '0), 1);
        check("vic_def", int'(defeat), 0);
        doSteps(5);
        check("vic_x", int'(xAlien), 32);
        check("vic_y", int'(yAlien), 32);
        hPos = 10'd32;
        vPos = 10'd32;
        push("vic_pix", 0, 0);
        tick();
        pop();

        doReset();
        step = 1'b1;
        n = 0;
        while (yAlien != 10'd352 && n < 20000) begin
            tick();
            n++;
        end
        check("defeat_bound", int'(n < 20000), 1);
        check("defeat_early", int'(defeat), 0);
        xHold = xAlien;
        tick();
        check("defeat_set", int'(defeat), 1);
        check("defeat_vic", int'(victory), 0);
        repeat (10) tick();
        step = 1'b0;
        check("frozen_x", int'(xAlien), int'(xHold));
        check("frozen_y", int'(yAlien), 352);

        reset = 1'b1;
        laserActive = 1'b1;
        xLaser = 10'd32;
        yLaser = 10'd32;
        tick();
        checkReset("midrst");
        reset = 1'b0;
        tick();
        check("post_rst_kill", int'(killingAlien), 1);
        laserActive = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
